rbm_regfile_axil: RTL and testbench
===================================

Name: rbm_regfile_axil

Overview:
Parametrised AXI4-Lite control/status register file for the RBM accelerator and trainer, replacing the condensed register shell with a complete protocol implementation. It provides:
- self-clearing command pulses (START, SOFT_RST);
- a persistent mode field;
- N_CFG generic 32-bit config registers with byte strobes;
- sticky W1C interrupt status fed by event pulses, with a maskable level IRQ.

It sits between the AXI interconnect and the rbm_core / trainer datapaths.

Parameters:
ADDR_W, 8, AXI address width (byte addresses, word aligned)
N_CFG, 16, number of generic config registers at 0x40 + 4*k, 1..(2^ADDR_W-64)/4
N_IRQ, 3, number of interrupt sources, 1..32
VERSION, 32'h0002_0000, value returned by VERSION register

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous active-high reset
s_awaddr  in  ADDR_W  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  00 OKAY, 10 SLVERR
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  ADDR_W  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  00 OKAY, 10 SLVERR
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
start_pulse  out  1  one-cycle start command
soft_rst_pulse  out  1  one-cycle soft reset command
ctrl_mode  out  8  CONTROL[15:8]
cfg_q  out  32*N_CFG  config registers, reg k at [32k+31:32k]
stat_busy  in  1  datapath busy
stat_err  in  1  datapath error level
irq_src  in  N_IRQ  one-cycle event pulses (done, batch, epoch, ...)
irq  out  1  level interrupt, registered

Behaviour:
Reset values:
- All ready/valid outputs 0; s_bresp/s_rresp 00; s_rdata 0.
- Pulses 0; ctrl_mode 0; cfg_q 0; INT_EN 0; INT_STATUS 0; irq 0.
- Ready outputs are asserted from the first cycle after rst deasserts.

Address map:
- 0x00 CONTROL: bit0 START (W1 pulse), bit1 SOFT_RST (W1 pulse), [15:8] mode (RW). Reads return 0 in bits 0-1.
- 0x04 STATUS (RO): bit0 busy, bit1 err, bit2 START_DROPPED (sticky).
- 0x08 INT_EN (RW): bits [N_IRQ-1:0].
- 0x0C INT_STATUS (W1C): bits [N_IRQ-1:0].
- 0x10 VERSION (RO).
- 0x40+4k CFG k (RW).
- Any other address: SLVERR, no side effect, read data 0.
- A write to a RO register gives OKAY and is ignored.

Write channel:
- AW and W are accepted independently. s_awready = no AW held and !s_bvalid; s_wready likewise for W.
- When both are held, the register updates with byte strobes applied; s_bvalid rises on the next edge and holds until s_bready.
- One outstanding write; back-to-back throughput is one write per 3 cycles minimum.

Read channel:
- s_arready = !s_rvalid.
- After the AR handshake, s_rdata/s_rresp/s_rvalid are registered on the next edge and held stable until s_rready.
- Reads have no side effects.

Command pulses:
- start_pulse asserts for exactly one cycle, the cycle after the CONTROL write commits with wdata[0]=1 and wstrb[0]=1.
- If stat_busy=1 at commit, the pulse is suppressed and START_DROPPED is set.
- START_DROPPED clears on the next accepted START.
- soft_rst_pulse asserts one cycle on a CONTROL write with wdata[1]=1. It also clears INT_STATUS and START_DROPPED; CFG, INT_EN and mode are retained.

Interrupts:
- INT_STATUS[n] sets on irq_src[n].
- A set in the same cycle as a W1C clear or soft reset wins.
- irq <= |(INT_STATUS & INT_EN), one-cycle latency after the status change.

Reset during an operation:
- rst mid-transaction drops all pending AW/W/B/R state immediately; no response is issued.

Optional Feature:
RBM_REGFILE_SHADOW_EN
- Defined: CFG writes land in staging registers, and readback returns the staging value. cfg_q loads from staging only on the clock edge that asserts an issued start_pulse, so cfg_q is stable while busy. Dropped STARTs do not load. rst clears both banks.
- Undefined: no staging; cfg_q follows the register, updating on the write-commit edge.

Test Plan:
1. Write 0x40=0xA5A5_1234 with wstrb=0xF, then read 0x40 -> bresp 00, rdata 0xA5A5_1234, rresp 00. Write wstrb=0x2 data 0x0000_FF00 -> readback 0xA5A5_FF34.
2. Issue AW 3 cycles before W, and separately W before AW -> single commit each time, exactly one bvalid. Hold bready=0 for 5 cycles -> bvalid and bresp stable, awready=0 throughout.
3. Write CONTROL=0x0000_0301 with stat_busy=0 -> start_pulse high exactly 1 cycle, ctrl_mode=0x03. Repeat with stat_busy=1 -> no pulse, STATUS=0x5.
4. INT_EN=0x5. Pulse irq_src=0x1 -> irq=1 one cycle later. Write INT_STATUS=0x1 in the same cycle as irq_src[0] -> bit remains set. W1C again later -> irq=0.
5. Read 0x20 and write 0x24 -> rresp/bresp 10, rdata 0, no register changes. Read 0x10 -> 0x0002_0000.
6. (SHADOW_EN) Write CFG0=0x11, then START -> cfg_q[31:0]=0x11 on the start edge. Write CFG0=0x22 while busy -> cfg_q unchanged and readback 0x22.

Source files
------------

// File: rtl/rbm_regfile_axil.sv
// rbm_regfile_axil -- AXI4-Lite control/status register file for the RBM
// accelerator and trainer.
//
// Register map (byte addresses, word aligned):
//   0x00 CONTROL    bit0 START (write-1 pulse), bit1 SOFT_RST (write-1 pulse),
//                   [15:8] mode (RW); bits 1:0 read back as 0
//   0x04 STATUS     RO: bit0 busy, bit1 err, bit2 START_DROPPED (sticky)
//   0x08 INT_EN     RW, bits [N_IRQ-1:0]
//   0x0C INT_STATUS W1C, bits [N_IRQ-1:0], set by irq_src pulses
//   0x10 VERSION    RO
//   0x40+4k CFG k   RW, k = 0..N_CFG-1
//   Unmapped addresses answer SLVERR with no side effect.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*     AXI4-Lite write channels (one outstanding write)
//   s_ar*/s_r*          AXI4-Lite read channels
//   start_pulse         one-cycle START command (suppressed while stat_busy)
//   soft_rst_pulse      one-cycle soft reset command
//   ctrl_mode           CONTROL[15:8]
//   cfg_q               config registers, reg k at [32k+31:32k]
//   stat_busy, stat_err datapath status levels
//   irq_src             one-cycle interrupt event pulses
//   irq                 registered level interrupt |(INT_STATUS & INT_EN)
//
// Build option: define RBM_REGFILE_SHADOW_EN to stage CFG writes; cfg_q then
// loads from the staging bank only on the edge that issues start_pulse.
module rbm_regfile_axil #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned N_CFG   = 16,
  parameter int unsigned N_IRQ   = 3,
  parameter logic [31:0] VERSION = 32'h0002_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    s_awaddr,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [31:0]          s_wdata,
  input  logic [3:0]           s_wstrb,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  output logic [1:0]           s_bresp,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  input  logic [ADDR_W-1:0]    s_araddr,
  input  logic                 s_arvalid,
  output logic                 s_arready,
  output logic [31:0]          s_rdata,
  output logic [1:0]           s_rresp,
  output logic                 s_rvalid,
  input  logic                 s_rready,
  output logic                 start_pulse,
  output logic                 soft_rst_pulse,
  output logic [7:0]           ctrl_mode,
  output logic [32*N_CFG-1:0]  cfg_q,
  input  logic                 stat_busy,
  input  logic                 stat_err,
  input  logic [N_IRQ-1:0]     irq_src,
  output logic                 irq
);

  typedef enum logic [2:0] {
    SEL_CTRL, SEL_STAT, SEL_INTEN, SEL_INTST, SEL_VER, SEL_CFG, SEL_BAD
  } sel_e;

  function automatic sel_e decode(input logic [ADDR_W-1:0] addr);
    logic [31:0] a;
    a = 32'(addr);
    if (a[1:0] != 2'b00) begin
      return SEL_BAD;
    end else begin
      case (a)
        32'h00:  return SEL_CTRL;
        32'h04:  return SEL_STAT;
        32'h08:  return SEL_INTEN;
        32'h0C:  return SEL_INTST;
        32'h10:  return SEL_VER;
        default: return ((a >= 32'h40) && (((a - 32'h40) >> 2) < N_CFG)) ? SEL_CFG : SEL_BAD;
      endcase
    end
  endfunction

  function automatic logic [31:0] cfg_index(input logic [ADDR_W-1:0] addr);
    return (32'(addr) - 32'h40) >> 2;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  // channel state
  logic              init_q;
  logic              aw_held_q, w_held_q, bvalid_q, rvalid_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q, rdata_q;
  logic [3:0]        w_strb_q;
  logic [1:0]        bresp_q, rresp_q;
  // architectural registers
  logic [7:0]             mode_q, mode_d;
  logic [N_IRQ-1:0]       int_en_q, int_en_d, int_st_q, int_st_d, clr_s;
  logic                   dropped_q, dropped_d;
  logic                   start_q, soft_q, irq_q;
  logic [N_CFG-1:0][31:0] cfg_reg_q, cfg_d;
  // combinational helpers
  logic        commit_s, start_req_s, start_s, soft_s;
  sel_e        wr_sel_s, rd_sel_s;
  logic [31:0] wr_idx_s, rd_idx_s, wmask_s, rd_data_s;
  logic [1:0]  rd_resp_s;

  // readies are held low until the first edge after reset has released
  assign s_awready      = init_q & ~aw_held_q & ~bvalid_q;
  assign s_wready       = init_q & ~w_held_q & ~bvalid_q;
  assign s_arready      = init_q & ~rvalid_q;
  assign s_bvalid       = bvalid_q;
  assign s_bresp        = bresp_q;
  assign s_rvalid       = rvalid_q;
  assign s_rdata        = rdata_q;
  assign s_rresp        = rresp_q;
  assign start_pulse    = start_q;
  assign soft_rst_pulse = soft_q;
  assign ctrl_mode      = mode_q;
  assign irq            = irq_q;

  // Write decode: register next-state once both AW and W are held
  always_comb begin
    commit_s    = aw_held_q & w_held_q;
    wr_sel_s    = decode(aw_addr_q);
    wr_idx_s    = cfg_index(aw_addr_q);
    wmask_s     = strb_mask(w_strb_q);
    mode_d      = mode_q;
    int_en_d    = int_en_q;
    cfg_d       = cfg_reg_q;
    clr_s       = '0;
    start_req_s = 1'b0;
    soft_s      = 1'b0;
    if (commit_s) begin
      case (wr_sel_s)
        SEL_CTRL: begin
          if (w_strb_q[1]) mode_d = w_data_q[15:8];
          else             mode_d = mode_q;
          // both command bits live in byte 0, so they need its strobe
          start_req_s = w_strb_q[0] & w_data_q[0];
          soft_s      = w_strb_q[0] & w_data_q[1];
        end
        SEL_INTEN: int_en_d = (int_en_q & ~wmask_s[N_IRQ-1:0]) |
                              (w_data_q[N_IRQ-1:0] & wmask_s[N_IRQ-1:0]);
        SEL_INTST: clr_s = w_data_q[N_IRQ-1:0] & wmask_s[N_IRQ-1:0];
        SEL_CFG: begin
          for (int k = 0; k < int'(N_CFG); k++) begin
            if (wr_idx_s == 32'(k)) cfg_d[k] = (cfg_reg_q[k] & ~wmask_s) | (w_data_q & wmask_s);
          end
        end
        default: ; // RO and unmapped: no side effect
      endcase
    end else begin
      mode_d = mode_q;
    end
    start_s = start_req_s & ~stat_busy;
    // a new event in the same cycle as a clear takes precedence
    int_st_d = (soft_s ? '0 : (int_st_q & ~clr_s)) | irq_src;
    if (start_req_s)  dropped_d = stat_busy;
    else if (soft_s)  dropped_d = 1'b0;
    else              dropped_d = dropped_q;
  end

  // Read mux, sampled into the R registers on the AR handshake
  always_comb begin
    rd_sel_s  = decode(s_araddr);
    rd_idx_s  = cfg_index(s_araddr);
    rd_data_s = 32'h0;
    rd_resp_s = 2'b00;
    case (rd_sel_s)
      SEL_CTRL:  rd_data_s = {16'h0, mode_q, 8'h0};
      SEL_STAT:  rd_data_s = {29'h0, dropped_q, stat_err, stat_busy};
      SEL_INTEN: rd_data_s = 32'(int_en_q);
      SEL_INTST: rd_data_s = 32'(int_st_q);
      SEL_VER:   rd_data_s = VERSION;
      SEL_CFG: begin
        for (int k = 0; k < int'(N_CFG); k++) begin
          if (rd_idx_s == 32'(k)) rd_data_s = cfg_reg_q[k];
        end
      end
      default:   rd_resp_s = 2'b10;
    endcase
  end

  // AXI channel state: AW/W holding, B and R response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      init_q    <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= 2'b00;
    end else begin
      init_q <= 1'b1;
      if (s_awvalid && s_awready) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= s_awaddr;
      end
      if (s_wvalid && s_wready) begin
        w_held_q <= 1'b1;
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end
      if (commit_s) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= (wr_sel_s == SEL_BAD) ? 2'b10 : 2'b00;
      end else if (bvalid_q && s_bready) begin
        bvalid_q <= 1'b0;
      end
      if (s_arvalid && s_arready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data_s;
        rresp_q  <= rd_resp_s;
      end else if (rvalid_q && s_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Register bank, command pulses and interrupt output
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= 8'h0;
      int_en_q  <= '0;
      int_st_q  <= '0;
      dropped_q <= 1'b0;
      start_q   <= 1'b0;
      soft_q    <= 1'b0;
      irq_q     <= 1'b0;
      cfg_reg_q <= '0;
    end else begin
      mode_q    <= mode_d;
      int_en_q  <= int_en_d;
      int_st_q  <= int_st_d;
      dropped_q <= dropped_d;
      start_q   <= start_s;
      soft_q    <= soft_s;
      irq_q     <= |(int_st_q & int_en_q);
      cfg_reg_q <= cfg_d;
    end
  end

`ifdef RBM_REGFILE_SHADOW_EN
  logic [N_CFG-1:0][31:0] cfg_out_q;

  // Live bank: loads from staging only when a START is actually issued
  always_ff @(posedge clk) begin
    if (rst)          cfg_out_q <= '0;
    else if (start_s) cfg_out_q <= cfg_reg_q;
    else              cfg_out_q <= cfg_out_q;
  end

  assign cfg_q = cfg_out_q;
`else
  assign cfg_q = cfg_reg_q;
`endif

endmodule

// File: tb/tb_rbm_regfile_axil.sv
`timescale 1ns/1ps
module tb_rbm_regfile_axil;
  localparam int ADDR_W = 8;
  localparam int N_CFG  = 16;
  localparam int N_IRQ  = 3;
`ifdef RBM_REGFILE_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ADDR_W-1:0] s_awaddr = '0, s_araddr = '0;
  logic s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0;
  logic s_bready = 1'b1, s_rready = 1'b1;
  logic [31:0] s_wdata = 32'h0;
  logic [3:0]  s_wstrb = 4'h0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic start_pulse, soft_rst_pulse, irq;
  logic [7:0] ctrl_mode;
  logic [32*N_CFG-1:0] cfg_q;
  logic stat_busy = 1'b0, stat_err = 1'b0;
  logic [N_IRQ-1:0] irq_src = '0;

  always #5 clk = ~clk;

  rbm_regfile_axil #(.ADDR_W(ADDR_W), .N_CFG(N_CFG), .N_IRQ(N_IRQ), .VERSION(32'h0002_0000)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .start_pulse(start_pulse), .soft_rst_pulse(soft_rst_pulse), .ctrl_mode(ctrl_mode),
    .cfg_q(cfg_q), .stat_busy(stat_busy), .stat_err(stat_err), .irq_src(irq_src), .irq(irq)
  );

  int n_cmp = 0;
  int n_err = 0;
  int sp_cnt = 0, srp_cnt = 0, b_hs = 0;
  logic [33:0] exp_q[$];
  logic [33:0] e;
  logic [31:0] cfg0_reg_m = 32'h0;  // value software sees in CFG0
  logic [31:0] cfg0_m     = 32'h0;  // expected cfg_q[31:0]
  logic [1:0]  pulse_at_b;          // {start, soft} seen with bvalid
  logic [31:0] cfg0_at_b;
  logic [31:0] rdat;
  logic [1:0]  rrsp, brsp;
  int s0;

  // pulse and B-handshake counters
  always @(posedge clk) begin
    if (start_pulse) sp_cnt <= sp_cnt + 1;
    if (soft_rst_pulse) srp_cnt <= srp_cnt + 1;
    if (s_bvalid && s_bready) b_hs <= b_hs + 1;
  end

  task automatic wr(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input int aw_dly, input int w_dly, output logic [1:0] bresp);
    bit aw_done = 1'b0, w_done = 1'b0, hs_aw, hs_w;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    bresp = 2'bxx; pulse_at_b = 2'bxx; cfg0_at_b = 32'hx;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      if (!aw_done && c >= aw_dly) s_awvalid = 1'b1;
      if (!w_done && c >= w_dly) s_wvalid = 1'b1;
      hs_aw = s_awvalid & s_awready;
      hs_w  = s_wvalid & s_wready;
      @(posedge clk); #1;
      if (hs_aw) begin aw_done = 1'b1; s_awvalid = 1'b0; end
      if (hs_w)  begin w_done = 1'b1;  s_wvalid = 1'b0; end
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (s_bvalid) begin
        bresp = s_bresp;
        pulse_at_b = {start_pulse, soft_rst_pulse};
        cfg0_at_b = cfg_q[31:0];
        if (s_bready) begin @(posedge clk); #1; end
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic rd(input logic [ADDR_W-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit hs;
    s_araddr = addr; s_arvalid = 1'b1;
    data = 32'hx; resp = 2'bxx;
    for (int c = 0; c < 20; c++) begin
      hs = s_arready;
      @(posedge clk); #1;
      if (hs) break;
    end
    s_arvalid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (s_rvalid) begin
        data = s_rdata; resp = s_rresp;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp,
         start_pulse, soft_rst_pulse, irq, ctrl_mode} !== 20'h0) begin
      n_err++; $display("FAIL reset_ctl got %h expected 0", {s_awready, s_wready, s_arready,
        s_bvalid, s_rvalid, s_bresp, s_rresp, start_pulse, soft_rst_pulse, irq, ctrl_mode});
    end
    n_cmp++;
    if ({s_rdata, cfg_q} !== '0) begin n_err++; $display("FAIL reset_data got rdata=%h cfg0=%h expected 0", s_rdata, cfg_q[31:0]); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin n_err++; $display("FAIL ready_after_rst got %b expected 111", {s_awready, s_wready, s_arready}); end
    exp_q.push_back({2'b00, 32'h0}); rd(8'h0C, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL int_status_reset got %h expected %h", {rrsp, rdat}, e); end
    exp_q.push_back({2'b00, 32'h0}); rd(8'h08, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL int_en_reset got %h expected %h", {rrsp, rdat}, e); end
  endtask

  task automatic test_cfg_rw();
    exp_q.push_back({2'b00, 32'h0}); wr(8'h40, 32'hA5A5_1234, 4'hF, 0, 0, brsp);
    cfg0_reg_m = 32'hA5A5_1234; if (!SHADOW) cfg0_m = cfg0_reg_m;
    e = exp_q.pop_front();
    n_cmp++; if (brsp !== e[33:32]) begin n_err++; $display("FAIL cfg_bresp got %b expected %b", brsp, e[33:32]); end
    n_cmp++; if (cfg0_at_b !== cfg0_m) begin n_err++; $display("FAIL cfg_q_commit got %h expected %h", cfg0_at_b, cfg0_m); end
    exp_q.push_back({2'b00, 32'hA5A5_1234}); rd(8'h40, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL cfg_read got %h expected %h", {rrsp, rdat}, e); end
    wr(8'h40, 32'h0000_FF00, 4'h2, 0, 0, brsp);
    cfg0_reg_m = 32'hA5A5_FF34; if (!SHADOW) cfg0_m = cfg0_reg_m;
    exp_q.push_back({2'b00, 32'hA5A5_FF34}); rd(8'h40, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL cfg_strobe got %h expected %h", {rrsp, rdat}, e); end
  endtask

  task automatic test_split_aw_w();
    bit stable = 1'b1;
    s0 = b_hs;
    wr(8'h44, 32'h1111_2222, 4'hF, 0, 3, brsp);
    wr(8'h48, 32'h3333_4444, 4'hF, 3, 0, brsp);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (b_hs - s0 !== 2) begin n_err++; $display("FAIL split_b_count got %0d expected 2", b_hs - s0); end
    exp_q.push_back({2'b00, 32'h1111_2222}); rd(8'h44, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL aw_first got %h expected %h", {rrsp, rdat}, e); end
    exp_q.push_back({2'b00, 32'h3333_4444}); rd(8'h48, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL w_first got %h expected %h", {rrsp, rdat}, e); end
    s_bready = 1'b0;
    wr(8'h4C, 32'h0000_0055, 4'hF, 0, 0, brsp);
    repeat (5) begin
      @(posedge clk); #1;
      if (!(s_bvalid === 1'b1 && s_bresp === 2'b00 && s_awready === 1'b0 && s_wready === 1'b0)) stable = 1'b0;
    end
    n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL b_hold got %b expected 1", stable); end
    s_bready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (s_bvalid !== 1'b0) begin n_err++; $display("FAIL b_release got %b expected 0", s_bvalid); end
  endtask

  task automatic test_control();
    stat_busy = 1'b0; s0 = sp_cnt;
    wr(8'h00, 32'h0000_0301, 4'hF, 0, 0, brsp);
    if (SHADOW) cfg0_m = cfg0_reg_m;
    @(posedge clk); #1;
    n_cmp++; if (pulse_at_b[1] !== 1'b1) begin n_err++; $display("FAIL start_timing got %b expected 1", pulse_at_b[1]); end
    n_cmp++; if (sp_cnt - s0 !== 1) begin n_err++; $display("FAIL start_width got %0d expected 1", sp_cnt - s0); end
    n_cmp++; if (ctrl_mode !== 8'h03) begin n_err++; $display("FAIL ctrl_mode got %h expected 03", ctrl_mode); end
    n_cmp++; if (cfg_q[31:0] !== cfg0_m) begin n_err++; $display("FAIL cfg_q_after_start got %h expected %h", cfg_q[31:0], cfg0_m); end
    exp_q.push_back({2'b00, 32'h0000_0300}); rd(8'h00, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL ctrl_read got %h expected %h", {rrsp, rdat}, e); end
    stat_busy = 1'b1; s0 = sp_cnt;
    wr(8'h00, 32'h0000_0301, 4'hF, 0, 0, brsp);
    @(posedge clk); #1;
    n_cmp++; if (sp_cnt - s0 !== 0) begin n_err++; $display("FAIL start_busy got %0d expected 0", sp_cnt - s0); end
    exp_q.push_back({2'b00, 32'h0000_0005}); rd(8'h04, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL status_dropped got %h expected %h", {rrsp, rdat}, e); end
    stat_busy = 1'b0;
    wr(8'h00, 32'h0000_0301, 4'hF, 0, 0, brsp);
    exp_q.push_back({2'b00, 32'h0000_0000}); rd(8'h04, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL dropped_clear got %h expected %h", {rrsp, rdat}, e); end
  endtask

  task automatic test_irq();
    wr(8'h08, 32'h0000_0005, 4'hF, 0, 0, brsp);
    irq_src = 3'b001; @(posedge clk); #1; irq_src = 3'b000;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early got %b expected 0", irq); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rise got %b expected 1", irq); end
    fork
      wr(8'h0C, 32'h0000_0001, 4'hF, 0, 0, brsp);
      begin @(posedge clk); #1; irq_src = 3'b001; @(posedge clk); #1; irq_src = 3'b000; end
    join
    exp_q.push_back({2'b00, 32'h0000_0001}); rd(8'h0C, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL set_beats_clear got %h expected %h", {rrsp, rdat}, e); end
    wr(8'h0C, 32'h0000_0001, 4'hF, 0, 0, brsp);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_cleared got %b expected 0", irq); end
    irq_src = 3'b010; @(posedge clk); #1; irq_src = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_masked got %b expected 0", irq); end
    exp_q.push_back({2'b00, 32'h0000_0002}); rd(8'h0C, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL masked_status got %h expected %h", {rrsp, rdat}, e); end
  endtask

  task automatic test_soft_reset();
    stat_busy = 1'b1;
    wr(8'h00, 32'h0000_0301, 4'hF, 0, 0, brsp);
    stat_busy = 1'b0; s0 = srp_cnt;
    wr(8'h00, 32'h0000_0302, 4'hF, 0, 0, brsp);
    @(posedge clk); #1;
    n_cmp++; if (pulse_at_b !== 2'b01) begin n_err++; $display("FAIL soft_timing got %b expected 01", pulse_at_b); end
    n_cmp++; if (srp_cnt - s0 !== 1) begin n_err++; $display("FAIL soft_width got %0d expected 1", srp_cnt - s0); end
    exp_q.push_back({2'b00, 32'h0}); rd(8'h0C, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL soft_int_status got %h expected %h", {rrsp, rdat}, e); end
    exp_q.push_back({2'b00, 32'h0}); rd(8'h04, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL soft_dropped got %h expected %h", {rrsp, rdat}, e); end
    exp_q.push_back({2'b00, 32'h5}); rd(8'h08, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL soft_int_en got %h expected %h", {rrsp, rdat}, e); end
    exp_q.push_back({2'b00, cfg0_reg_m}); rd(8'h40, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e || ctrl_mode !== 8'h03) begin n_err++; $display("FAIL soft_retain got %h mode %h expected %h mode 03", {rrsp, rdat}, ctrl_mode, e); end
  endtask

  task automatic test_bad_addr();
    exp_q.push_back({2'b10, 32'h0}); rd(8'h20, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL bad_read got %h expected %h", {rrsp, rdat}, e); end
    exp_q.push_back({2'b10, 32'h0}); wr(8'h24, 32'hFFFF_FFFF, 4'hF, 0, 0, brsp); e = exp_q.pop_front();
    n_cmp++; if (brsp !== e[33:32]) begin n_err++; $display("FAIL bad_write got %b expected %b", brsp, e[33:32]); end
    exp_q.push_back({2'b00, cfg0_reg_m}); rd(8'h40, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e || ctrl_mode !== 8'h03) begin n_err++; $display("FAIL bad_no_effect got %h mode %h expected %h", {rrsp, rdat}, ctrl_mode, e); end
    exp_q.push_back({2'b00, 32'h0}); wr(8'h10, 32'h0, 4'hF, 0, 0, brsp); e = exp_q.pop_front();
    n_cmp++; if (brsp !== e[33:32]) begin n_err++; $display("FAIL ro_write got %b expected %b", brsp, e[33:32]); end
    exp_q.push_back({2'b00, 32'h0002_0000}); rd(8'h10, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL version got %h expected %h", {rrsp, rdat}, e); end
    wr(8'h7C, 32'hDEAD_BEEF, 4'hF, 0, 0, brsp);
    exp_q.push_back({2'b00, 32'hDEAD_BEEF}); rd(8'h7C, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL cfg_last got %h expected %h", {rrsp, rdat}, e); end
    exp_q.push_back({2'b10, 32'h0}); rd(8'h80, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL cfg_past_end got %h expected %h", {rrsp, rdat}, e); end
  endtask

  task automatic test_cfg_shadow();
    wr(8'h40, 32'h0000_0011, 4'hF, 0, 0, brsp);
    cfg0_reg_m = 32'h11; if (!SHADOW) cfg0_m = cfg0_reg_m;
    n_cmp++; if (cfg0_at_b !== cfg0_m) begin n_err++; $display("FAIL shadow_write got %h expected %h", cfg0_at_b, cfg0_m); end
    stat_busy = 1'b0;
    wr(8'h00, 32'h0000_0301, 4'hF, 0, 0, brsp);
    cfg0_m = cfg0_reg_m;
    n_cmp++; if (cfg0_at_b !== cfg0_m) begin n_err++; $display("FAIL shadow_load got %h expected %h", cfg0_at_b, cfg0_m); end
    stat_busy = 1'b1;
    wr(8'h40, 32'h0000_0022, 4'hF, 0, 0, brsp);
    cfg0_reg_m = 32'h22; if (!SHADOW) cfg0_m = cfg0_reg_m;
    n_cmp++; if (cfg0_at_b !== cfg0_m) begin n_err++; $display("FAIL shadow_busy got %h expected %h", cfg0_at_b, cfg0_m); end
    exp_q.push_back({2'b00, 32'h22}); rd(8'h40, rdat, rrsp); e = exp_q.pop_front();
    n_cmp++; if ({rrsp, rdat} !== e) begin n_err++; $display("FAIL shadow_readback got %h expected %h", {rrsp, rdat}, e); end
    wr(8'h00, 32'h0000_0301, 4'hF, 0, 0, brsp);
    n_cmp++; if (cfg_q[31:0] !== cfg0_m) begin n_err++; $display("FAIL shadow_dropped got %h expected %h", cfg_q[31:0], cfg0_m); end
    stat_busy = 1'b0;
  endtask

  task automatic test_rst_mid();
    bit quiet = 1'b1;
    s_awaddr = 8'h40; s_awvalid = 1'b1; s_araddr = 8'h40; s_arvalid = 1'b1;
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_arvalid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if ({s_bvalid, s_rvalid} !== 2'b00) begin n_err++; $display("FAIL rst_mid_resp got %b expected 00", {s_bvalid, s_rvalid}); end
    s_wdata = 32'h77; s_wstrb = 4'hF;
    repeat (4) begin
      @(posedge clk); #1;
      if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0) quiet = 1'b0;
    end
    n_cmp++; if (quiet !== 1'b1 || s_awready !== 1'b1) begin n_err++; $display("FAIL rst_mid_drop got quiet=%b awready=%b expected 1 1", quiet, s_awready); end
    n_cmp++; if (cfg_q !== '0) begin n_err++; $display("FAIL rst_mid_cfg got %h expected 0", cfg_q[31:0]); end
  endtask

  initial begin
    test_reset();
    test_cfg_rw();
    test_split_aw_w();
    test_control();
    test_irq();
    test_soft_reset();
    test_bad_addr();
    test_cfg_shadow();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
